mesh_xy_router: RTL and testbench

- One node of the match-engine 2D mesh; sits directly downstream of mesh_dual_fifo.
- The dual-FIFO serialised stream enters as the local injection port. Flits from the west and north neighbours merge with it.
- Dimension-ordered XY routing: X first (eastward), then Y (southward), then eject. Each output port has a round-robin arbiter and a one-entry registered output stage.

---
 rtl/mesh_xy_router.sv | 197 +++++++++++++++++++
 tb/tb_mesh_xy_router.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_xy_router.sv
// mesh_xy_router: one node of the match-engine mesh; inputs l/w/n, outputs e/s/j, XY routing.
// Define MESH_XY_ROUTER_ERR_EN to add the sticky o_err illegal-destination detector.
module mesh_xy_router #(
  parameter int W      = 8,
  parameter int X_SIZE = 4,
  parameter int Y_SIZE = 4,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MESH_XY_ROUTER_ERR_EN
  output logic                      o_err,
`endif
  input  logic                      i_l_valid,
  input  logic [$clog2(X_SIZE)-1:0] i_l_dst_x,
  input  logic [$clog2(Y_SIZE)-1:0] i_l_dst_y,
  input  logic [W-1:0]              i_l_payload,
  output logic                      i_l_ready,
  input  logic                      i_w_valid,
  input  logic [$clog2(X_SIZE)-1:0] i_w_dst_x,
  input  logic [$clog2(Y_SIZE)-1:0] i_w_dst_y,
  input  logic [W-1:0]              i_w_payload,
  output logic                      i_w_ready,
  input  logic                      i_n_valid,
  input  logic [$clog2(X_SIZE)-1:0] i_n_dst_x,
  input  logic [$clog2(Y_SIZE)-1:0] i_n_dst_y,
  input  logic [W-1:0]              i_n_payload,
  output logic                      i_n_ready,
  output logic                      o_e_valid,
  output logic [$clog2(X_SIZE)-1:0] o_e_dst_x,
  output logic [$clog2(Y_SIZE)-1:0] o_e_dst_y,
  output logic [W-1:0]              o_e_payload,
  input  logic                      o_e_ready,
  output logic                      o_s_valid,
  output logic [$clog2(X_SIZE)-1:0] o_s_dst_x,
  output logic [$clog2(Y_SIZE)-1:0] o_s_dst_y,
  output logic [W-1:0]              o_s_payload,
  input  logic                      o_s_ready,
  output logic                      o_j_valid,
  output logic [$clog2(X_SIZE)-1:0] o_j_dst_x,
  output logic [$clog2(Y_SIZE)-1:0] o_j_dst_y,
  output logic [W-1:0]              o_j_payload,
  input  logic                      o_j_ready
);
  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);

  localparam logic [1:0] PTR_L = 2'd0;
  localparam logic [1:0] PTR_W = 2'd1;
  localparam logic [1:0] PTR_N = 2'd2;

  localparam logic [1:0] OUT_E = 2'd0;
  localparam logic [1:0] OUT_S = 2'd1;
  localparam logic [1:0] OUT_J = 2'd2;

  // Index 0/1/2 means l/w/n on the input side and e/s/j on the output side.
  logic [2:0]    in_valid;
  logic [XW-1:0] in_dx [3];
  logic [YW-1:0] in_dy [3];
  logic [W-1:0]  in_pl [3];
  logic [1:0]    route [3];
  logic [2:0]    illegal;
  logic [2:0]    req   [3];
  logic [2:0]    grant [3];
  logic [2:0]    can_load;
  logic [2:0]    out_ready;
  logic [2:0]    in_ready;
  logic [1:0]    ptr   [3];

  logic [2:0]    slot_v;
  logic [XW-1:0] slot_dx [3];
  logic [YW-1:0] slot_dy [3];
  logic [W-1:0]  slot_pl [3];
  logic [XW-1:0] sel_dx  [3];
  logic [YW-1:0] sel_dy  [3];
  logic [W-1:0]  sel_pl  [3];

  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] g;
    case (p)
      PTR_W:   g = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
      PTR_N:   g = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
      default: g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] ptr_after(input logic [2:0] g);
    logic [1:0] n;
    if (g[0])      n = PTR_W;
    else if (g[1]) n = PTR_N;
    else           n = PTR_L;
    return n;
  endfunction

  assign in_valid  = {i_n_valid, i_w_valid, i_l_valid};
  assign out_ready = {o_j_ready, o_s_ready, o_e_ready};
  assign in_dx[0] = i_l_dst_x;   assign in_dy[0] = i_l_dst_y;   assign in_pl[0] = i_l_payload;
  assign in_dx[1] = i_w_dst_x;   assign in_dy[1] = i_w_dst_y;   assign in_pl[1] = i_w_payload;
  assign in_dx[2] = i_n_dst_x;   assign in_dy[2] = i_n_dst_y;   assign in_pl[2] = i_n_payload;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      if (in_dx[p] != XW'(X_ID))      route[p] = OUT_E;
      else if (in_dy[p] != YW'(Y_ID)) route[p] = OUT_S;
      else                            route[p] = OUT_J;
    end
  end

`ifdef MESH_XY_ROUTER_ERR_EN
  // Destinations behind us or off the mesh edge can never be delivered; swallow them.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      illegal[p] = in_valid[p] &&
                   ((int'(in_dx[p]) < X_ID) || (int'(in_dy[p]) < Y_ID) ||
                    (route[p] == OUT_E && X_ID == X_SIZE - 1) ||
                    (route[p] == OUT_S && Y_ID == Y_SIZE - 1));
    end
  end
`else
  assign illegal = 3'b000;
`endif

  always_comb begin
    for (int q = 0; q < 3; q++) begin
      req[q] = 3'b000;
      for (int p = 0; p < 3; p++) begin
        req[q][p] = in_valid[p] && !illegal[p] && (route[p] == 2'(q));
      end
    end
  end

  always_comb begin
    for (int q = 0; q < 3; q++) begin
      can_load[q] = !slot_v[q] || out_ready[q];
      grant[q]    = can_load[q] ? rr_pick(req[q], ptr[q]) : 3'b000;
      sel_dx[q]   = grant[q][2] ? in_dx[2] : grant[q][1] ? in_dx[1] : in_dx[0];
      sel_dy[q]   = grant[q][2] ? in_dy[2] : grant[q][1] ? in_dy[1] : in_dy[0];
      sel_pl[q]   = grant[q][2] ? in_pl[2] : grant[q][1] ? in_pl[1] : in_pl[0];
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      in_ready[p] = !rst && (illegal[p] || grant[0][p] || grant[1][p] || grant[2][p]);
    end
  end

  assign i_l_ready = in_ready[0];
  assign i_w_ready = in_ready[1];
  assign i_n_ready = in_ready[2];

  // A grant already implies the slot can load, so loading covers the drain-and-refill case.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < 3; q++) begin
        slot_v[q]  <= 1'b0;
        slot_dx[q] <= '0;
        slot_dy[q] <= '0;
        slot_pl[q] <= '0;
        ptr[q]     <= PTR_L;
      end
    end else begin
      for (int q = 0; q < 3; q++) begin
        if (|grant[q]) begin
          slot_v[q]  <= 1'b1;
          slot_dx[q] <= sel_dx[q];
          slot_dy[q] <= sel_dy[q];
          slot_pl[q] <= sel_pl[q];
          ptr[q]     <= ptr_after(grant[q]);
        end else if (out_ready[q]) begin
          slot_v[q]  <= 1'b0;
        end
      end
    end
  end

`ifdef MESH_XY_ROUTER_ERR_EN
  logic err;

  always_ff @(posedge clk) begin
    if (rst)           err <= 1'b0;
    else if (|illegal) err <= 1'b1;
  end

  assign o_err = err;
`endif

  assign o_e_valid = slot_v[0];  assign o_e_dst_x = slot_dx[0];
  assign o_e_dst_y = slot_dy[0]; assign o_e_payload = slot_pl[0];
  assign o_s_valid = slot_v[1];  assign o_s_dst_x = slot_dx[1];
  assign o_s_dst_y = slot_dy[1]; assign o_s_payload = slot_pl[1];
  assign o_j_valid = slot_v[2];  assign o_j_dst_x = slot_dx[2];
  assign o_j_dst_y = slot_dy[2]; assign o_j_payload = slot_pl[2];

endmodule

// File: tb/tb_mesh_xy_router.sv
// Directed self-checking bench for mesh_xy_router at node (1,1) of a 4x4 mesh.
// With MESH_XY_ROUTER_ERR_EN defined it also exercises the sticky o_err path.
module tb_mesh_xy_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       l_valid, w_valid, n_valid;
  logic [1:0] l_dst_x, l_dst_y, w_dst_x, w_dst_y, n_dst_x, n_dst_y;
  logic [7:0] l_payload, w_payload, n_payload;
  logic       l_ready, w_ready, n_ready;
  logic       e_valid, s_valid, j_valid;
  logic [1:0] e_dst_x, e_dst_y, s_dst_x, s_dst_y, j_dst_x, j_dst_y;
  logic [7:0] e_payload, s_payload, j_payload;
  logic       e_ready, s_ready, j_ready;
`ifdef MESH_XY_ROUTER_ERR_EN
  logic       err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mesh_xy_router #(.W(8), .X_SIZE(4), .Y_SIZE(4), .X_ID(1), .Y_ID(1)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MESH_XY_ROUTER_ERR_EN
    .o_err(err),
`endif
    .i_l_valid(l_valid), .i_l_dst_x(l_dst_x), .i_l_dst_y(l_dst_y),
    .i_l_payload(l_payload), .i_l_ready(l_ready),
    .i_w_valid(w_valid), .i_w_dst_x(w_dst_x), .i_w_dst_y(w_dst_y),
    .i_w_payload(w_payload), .i_w_ready(w_ready),
    .i_n_valid(n_valid), .i_n_dst_x(n_dst_x), .i_n_dst_y(n_dst_y),
    .i_n_payload(n_payload), .i_n_ready(n_ready),
    .o_e_valid(e_valid), .o_e_dst_x(e_dst_x), .o_e_dst_y(e_dst_y),
    .o_e_payload(e_payload), .o_e_ready(e_ready),
    .o_s_valid(s_valid), .o_s_dst_x(s_dst_x), .o_s_dst_y(s_dst_y),
    .o_s_payload(s_payload), .o_s_ready(s_ready),
    .o_j_valid(j_valid), .o_j_dst_x(j_dst_x), .o_j_dst_y(j_dst_y),
    .o_j_payload(j_payload), .o_j_ready(j_ready)
  );

  // p: 0 = local, 1 = west, 2 = north
  task automatic applyStimulus(input int p, input logic v, input logic [1:0] x,
                               input logic [1:0] y, input logic [7:0] pl);
    case (p)
      0:       begin l_valid = v; l_dst_x = x; l_dst_y = y; l_payload = pl; end
      1:       begin w_valid = v; w_dst_x = x; w_dst_y = y; w_payload = pl; end
      default: begin n_valid = v; n_dst_x = x; n_dst_y = y; n_payload = pl; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 2'd0, 2'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    e_ready = 1'b1; s_ready = 1'b1; j_ready = 1'b1;
    clearInputs();
    applyStimulus(0, 1'b1, 2'd2, 2'd1, 8'hEE);
    tick();
    tick();
    checkOutput("rst_l_ready", l_ready, 0);
    checkOutput("rst_e_valid", e_valid, 0);
    checkOutput("rst_s_valid", s_valid, 0);
    checkOutput("rst_j_valid", j_valid, 0);
    checkOutput("rst_e_payload", e_payload, 0);
`ifdef MESH_XY_ROUTER_ERR_EN
    checkOutput("rst_err", err, 0);
`endif
    clearInputs();
    rst = 1'b0;
    tick();

    $display("[TB] single local flit routed east");
    applyStimulus(0, 1'b1, 2'd2, 2'd1, 8'hA5);
    #1;
    checkOutput("t1_l_ready", l_ready, 1);
    checkOutput("t1_w_ready_idle", w_ready, 0);
    tick();
    applyStimulus(0, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t1_e_valid", e_valid, 1);
    checkOutput("t1_e_dst_x", e_dst_x, 2);
    checkOutput("t1_e_dst_y", e_dst_y, 1);
    checkOutput("t1_e_payload", e_payload, 8'hA5);
    checkOutput("t1_s_valid", s_valid, 0);
    checkOutput("t1_j_valid", j_valid, 0);
    tick();
    checkOutput("t1_e_drained", e_valid, 0);

    $display("[TB] three-way contention on eject");
    applyStimulus(0, 1'b1, 2'd1, 2'd1, 8'h11);
    applyStimulus(1, 1'b1, 2'd1, 2'd1, 8'h22);
    applyStimulus(2, 1'b1, 2'd1, 2'd1, 8'h33);
    #1;
    checkOutput("t2_l_ready", l_ready, 1);
    checkOutput("t2_w_ready", w_ready, 0);
    checkOutput("t2_n_ready", n_ready, 0);
    tick();
    applyStimulus(0, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t2_j_first", j_payload, 8'h11);
    #1;
    checkOutput("t2_w_ready2", w_ready, 1);
    tick();
    applyStimulus(1, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t2_j_second", j_payload, 8'h22);
    #1;
    checkOutput("t2_n_ready3", n_ready, 1);
    tick();
    applyStimulus(2, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t2_j_third", j_payload, 8'h33);
    checkOutput("t2_j_valid3", j_valid, 1);
    applyStimulus(0, 1'b1, 2'd1, 2'd1, 8'h44);
    applyStimulus(1, 1'b1, 2'd1, 2'd1, 8'h55);
    #1;
    checkOutput("t2_ptr_back_l", l_ready, 1);
    checkOutput("t2_ptr_back_w", w_ready, 0);
    tick();
    applyStimulus(0, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t2_j_fourth", j_payload, 8'h44);
    #1;
    checkOutput("t2_w_ready5", w_ready, 1);
    tick();
    applyStimulus(1, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t2_j_fifth", j_payload, 8'h55);
    tick();
    checkOutput("t2_j_drained", j_valid, 0);

    $display("[TB] parallel east and south grants");
    applyStimulus(1, 1'b1, 2'd3, 2'd2, 8'hB1);
    applyStimulus(2, 1'b1, 2'd1, 2'd2, 8'hC2);
    #1;
    checkOutput("t3_w_ready", w_ready, 1);
    checkOutput("t3_n_ready", n_ready, 1);
    tick();
    clearInputs();
    checkOutput("t3_e_valid", e_valid, 1);
    checkOutput("t3_e_payload", e_payload, 8'hB1);
    checkOutput("t3_e_dst_x", e_dst_x, 3);
    checkOutput("t3_s_valid", s_valid, 1);
    checkOutput("t3_s_payload", s_payload, 8'hC2);
    checkOutput("t3_s_dst_y", s_dst_y, 2);
    checkOutput("t3_j_valid", j_valid, 0);
    tick();

    $display("[TB] south backpressure");
    s_ready = 1'b0;
    applyStimulus(0, 1'b1, 2'd1, 2'd3, 8'h60);
    #1;
    checkOutput("t4_l_first_ready", l_ready, 1);
    tick();
    applyStimulus(0, 1'b1, 2'd1, 2'd3, 8'h61);
    applyStimulus(2, 1'b1, 2'd1, 2'd2, 8'h70);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", s_valid, 1);
      checkOutput("t4_hold_payload", s_payload, 8'h60);
      checkOutput("t4_hold_dst_y", s_dst_y, 3);
      checkOutput("t4_stall_l", l_ready, 0);
      checkOutput("t4_stall_n", n_ready, 0);
      tick();
    end
    s_ready = 1'b1;
    #1;
    checkOutput("t4_release_n", n_ready, 1);
    checkOutput("t4_release_l", l_ready, 0);
    tick();
    applyStimulus(2, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t4_out_n", s_payload, 8'h70);
    checkOutput("t4_out_n_dst_y", s_dst_y, 2);
    #1;
    checkOutput("t4_l_ready_after", l_ready, 1);
    tick();
    applyStimulus(0, 1'b0, 2'd0, 2'd0, 8'h00);
    checkOutput("t4_out_l", s_payload, 8'h61);
    checkOutput("t4_out_l_valid", s_valid, 1);
    tick();
    checkOutput("t4_s_drained", s_valid, 0);

    $display("[TB] reset with all slots full");
    e_ready = 1'b0; s_ready = 1'b0; j_ready = 1'b0;
    applyStimulus(0, 1'b1, 2'd2, 2'd1, 8'h81);
    applyStimulus(1, 1'b1, 2'd1, 2'd2, 8'h82);
    applyStimulus(2, 1'b1, 2'd1, 2'd1, 8'h83);
    #1;
    checkOutput("t5_fill_l", l_ready, 1);
    checkOutput("t5_fill_w", w_ready, 1);
    checkOutput("t5_fill_n", n_ready, 1);
    tick();
    clearInputs();
    checkOutput("t5_full_e", e_valid, 1);
    checkOutput("t5_full_s", s_valid, 1);
    checkOutput("t5_full_j", j_valid, 1);
    rst = 1'b1;
    applyStimulus(0, 1'b1, 2'd3, 2'd1, 8'h90);
    #1;
    checkOutput("t5_rst_l_ready", l_ready, 0);
    tick();
    checkOutput("t5_rst_e_valid", e_valid, 0);
    checkOutput("t5_rst_s_valid", s_valid, 0);
    checkOutput("t5_rst_j_valid", j_valid, 0);
    checkOutput("t5_rst_e_payload", e_payload, 0);
    checkOutput("t5_rst_s_payload", s_payload, 0);
    checkOutput("t5_rst_j_payload", j_payload, 0);
    checkOutput("t5_rst_e_dst_x", e_dst_x, 0);
    checkOutput("t5_rst_s_dst_y", s_dst_y, 0);
    rst = 1'b0;
    e_ready = 1'b1; s_ready = 1'b1; j_ready = 1'b1;
    applyStimulus(0, 1'b1, 2'd3, 2'd1, 8'h91);
    applyStimulus(1, 1'b1, 2'd3, 2'd1, 8'h92);
    applyStimulus(2, 1'b1, 2'd3, 2'd1, 8'h93);
    #1;
    checkOutput("t5_post_l", l_ready, 1);
    checkOutput("t5_post_w", w_ready, 0);
    checkOutput("t5_post_n", n_ready, 0);
    tick();
    clearInputs();
    checkOutput("t5_post_e_payload", e_payload, 8'h91);
    tick();
    tick();

`ifdef MESH_XY_ROUTER_ERR_EN
    $display("[TB] illegal destination drop");
    applyStimulus(1, 1'b1, 2'd0, 2'd1, 8'h99);
    #1;
    checkOutput("t6_w_ready", w_ready, 1);
    checkOutput("t6_err_before", err, 0);
    tick();
    clearInputs();
    checkOutput("t6_e_valid", e_valid, 0);
    checkOutput("t6_s_valid", s_valid, 0);
    checkOutput("t6_j_valid", j_valid, 0);
    checkOutput("t6_err_set", err, 1);
    tick();
    tick();
    tick();
    checkOutput("t6_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_err_cleared", err, 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
